vga_ram_scanout: RTL and testbench



---
 rtl/vga_ram_scanout.sv | 186 ++++++++++++++++++
 tb/tb_vga_ram_scanout.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ram_scanout.sv
// RAM-to-VGA scanout: reads a grayscale byte image from RAM port b and
// streams it as upscaled VGA video with sync, blanking and a frame pulse.
module vga_ram_scanout #(
    parameter int         CLK_DIV    = 2,
    parameter int         RAM_LAT    = 2,
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33,
    parameter int         IMG_W      = 100,
    parameter int         IMG_H      = 100,
    parameter int         IMG_BASE   = 0,
    parameter int         SCALE_LOG2 = 2,
    parameter logic [7:0] BG         = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ram_addr,
    input  logic [7:0]  ram_q,
    output logic        vga_clk,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_MASK = HW'((1 << SCALE_LOG2) - 1);

    localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_LOG2) - 1);

    localparam logic [31:0] IMG_PW = 32'(IMG_W << SCALE_LOG2);
    localparam logic [31:0] IMG_PH = 32'(IMG_H << SCALE_LOG2);
    localparam logic [14:0] W15    = 15'(IMG_W);
    localparam logic [14:0] BASE15 = 15'(IMG_BASE);

    if (RAM_LAT > CLK_DIV) begin : g_lat_check
        $error("RAM_LAT must not exceed CLK_DIV");
    end

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [14:0]   row_q, row_d;
    logic [14:0]   col_q, col_d;
    logic [14:0]   addr_q, addr_d;
    logic          in_q, in_d;
    logic          act_q, act_d;
    logic          phs_q, phs_d;
    logic          pvs_q, pvs_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          bn_q, bn_d;
    logic          fs_q, fs_d;
    logic          vclk_q, vclk_d;

    logic tick, h_end, v_end, in_img, active;

    always_comb begin
        tick   = (div_q == DIV_MAX);
        h_end  = (h_q == H_MAX);
        v_end  = (v_q == V_MAX);
        in_img = (32'(h_q) < IMG_PW) && (32'(v_q) < IMG_PH);
        active = (h_q < H_ACT) && (v_q < V_ACT);

        div_d  = tick ? '0 : div_q + DW'(1);
        vclk_d = (div_d >= DIV_HALF);
        h_d    = h_q;
        v_d    = v_q;
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        in_d   = in_q;
        act_d  = act_q;
        phs_d  = phs_q;
        pvs_d  = pvs_q;
        rgb_d  = rgb_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        bn_d   = bn_q;
        fs_d   = 1'b0;

        if (tick) begin
            h_d = h_end ? '0 : h_q + HW'(1);
            if (h_end) begin
                v_d   = v_end ? '0 : v_q + VW'(1);
                col_d = '0;
                // row_base steps by one image row per 2^S screen lines
                if (v_end)
                    row_d = '0;
                else if ((v_q & V_MASK) == V_MASK)
                    row_d = row_q + W15;
            end else if ((h_q & H_MASK) == H_MASK) begin
                col_d = col_q + 15'd1;
            end

            addr_d = in_img ? (BASE15 + row_q + col_q) : BASE15;
            in_d   = in_img && active;
            act_d  = active;
            phs_d  = !((h_q >= HS_BEG) && (h_q <= HS_END));
            pvs_d  = !((v_q >= VS_BEG) && (v_q <= VS_END));
            fs_d   = (h_q == '0) && (v_q == '0);

            // previous pixel's RAM data has settled by this tick
            rgb_d = in_q ? ram_q : (act_q ? BG : 8'h00);
            hs_d  = phs_q;
            vs_d  = pvs_q;
            bn_d  = act_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= BASE15;
            in_q   <= 1'b0;
            act_q  <= 1'b0;
            phs_q  <= 1'b1;
            pvs_q  <= 1'b1;
            rgb_q  <= 8'h00;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            bn_q   <= 1'b0;
            fs_q   <= 1'b0;
            vclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
            in_q   <= in_d;
            act_q  <= act_d;
            phs_q  <= phs_d;
            pvs_q  <= pvs_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            bn_q   <= bn_d;
            fs_q   <= fs_d;
            vclk_q <= vclk_d;
        end
    end

    assign ram_addr    = {17'b0, addr_q};
    assign vga_clk     = vclk_q;
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign vga_blank_n = bn_q;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = rgb_q;
    assign vga_g       = rgb_q;
    assign vga_b       = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_ram_scanout.sv
// Bench for vga_ram_scanout: two reduced-timing instances with RAM models,
// a per-pixel scoreboard, a hand-derived pixel table and sync/period checks.
module tb_vga_ram_scanout;

    localparam int HA = 40, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;

    localparam int         CD  [2] = '{2, 4};
    localparam int         LT  [2] = '{2, 3};
    localparam int         IW  [2] = '{10, 50};
    localparam int         IH  [2] = '{5, 30};
    localparam int         IB  [2] = '{0, 1024};
    localparam int         SL  [2] = '{2, 0};
    localparam logic [7:0] BGV [2] = '{8'h20, 8'h10};

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       bn;
    } exp_t;

    typedef struct {
        int          g;
        int          h;
        int          v;
        logic [31:0] addr;
        logic [7:0]  rgb;
        logic        bn;
    } vec_t;

    localparam int NV = 13;

    logic        clk;
    logic        rst;
    logic [31:0] addr_w [2];
    logic [7:0]  q_w    [2];
    logic        vclk_w [2];
    logic        hs_w   [2];
    logic        vs_w   [2];
    logic        bn_w   [2];
    logic        sn_w   [2];
    logic [7:0]  r_w    [2];
    logic [7:0]  g_w    [2];
    logic [7:0]  b_w    [2];
    logic        fs_w   [2];

    for (genvar g = 0; g < 2; g++) begin : u
        if (LT[g] == 2) begin : l2
            logic [7:0] p0;
            always @(posedge clk) p0 <= addr_w[g][7:0];
            assign q_w[g] = p0;
        end else begin : l3
            logic [7:0] p0, p1;
            always @(posedge clk) begin
                p0 <= addr_w[g][7:0];
                p1 <= p0;
            end
            assign q_w[g] = p1;
        end

        vga_ram_scanout #(
            .CLK_DIV(CD[g]), .RAM_LAT(LT[g]),
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
            .IMG_W(IW[g]), .IMG_H(IH[g]), .IMG_BASE(IB[g]),
            .SCALE_LOG2(SL[g]), .BG(BGV[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .ram_addr(addr_w[g]),
            .ram_q(q_w[g]),
            .vga_clk(vclk_w[g]),
            .vga_hsync(hs_w[g]),
            .vga_vsync(vs_w[g]),
            .vga_blank_n(bn_w[g]),
            .vga_sync_n(sn_w[g]),
            .vga_r(r_w[g]),
            .vga_g(g_w[g]),
            .vga_b(b_w[g]),
            .frame_start(fs_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cc      = 0;
    vec_t tbl [NV];

    int         md [2], mh [2], mv [2];
    exp_t       sb [2][$];
    int         last_hf [2], last_vf [2], last_fs [2];
    logic       hs_prev [2], vs_prev [2];
    logic       tp_valid [2];
    logic [7:0] tp_rgb [2];
    logic       tp_bn [2];

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cc=%0d got=%0h want=%0h",
                     nm, g, cc, act, exp);
        end
    endtask

    task automatic step(input int g);
        exp_t        e;
        logic [31:0] ea;
        logic        inb, act;
        int          ph, pv, cd;
        cd = CD[g];
        if (rst) begin
            md[g] = 0;
            mh[g] = 0;
            mv[g] = 0;
            sb[g].delete();
            last_hf[g] = -1;
            last_vf[g] = -1;
            last_fs[g] = -1;
            tp_valid[g] = 1'b0;
            hs_prev[g] = 1'b1;
            vs_prev[g] = 1'b1;
            chk("rst_hsync", g, 32'(hs_w[g]), 32'd1);
            chk("rst_vsync", g, 32'(vs_w[g]), 32'd1);
            chk("rst_blank_n", g, 32'(bn_w[g]), 32'd0);
            chk("rst_rgb", g, {8'h0, r_w[g], g_w[g], b_w[g]}, 32'd0);
            chk("rst_addr", g, addr_w[g], 32'(IB[g]));
            chk("rst_frame_start", g, 32'(fs_w[g]), 32'd0);
            chk("rst_vga_clk", g, 32'(vclk_w[g]), 32'd0);
            return;
        end
        if (md[g] == cd - 1) begin
            md[g] = 0;
            if (sb[g].size() > 0)
                e = sb[g].pop_front();
            else
                e = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, bn: 1'b0};
            chk("rgb", g, {8'h0, r_w[g], g_w[g], b_w[g]},
                {8'h0, e.rgb, e.rgb, e.rgb});
            chk("hsync", g, 32'(hs_w[g]), 32'(e.hs));
            chk("vsync", g, 32'(vs_w[g]), 32'(e.vs));
            chk("blank_n", g, 32'(bn_w[g]), 32'(e.bn));
            if (tp_valid[g]) begin
                chk("tbl_rgb", g, 32'(r_w[g]), 32'(tp_rgb[g]));
                chk("tbl_blank_n", g, 32'(bn_w[g]), 32'(tp_bn[g]));
                tp_valid[g] = 1'b0;
            end

            ph  = mh[g];
            pv  = mv[g];
            inb = (ph < (IW[g] << SL[g])) && (pv < (IH[g] << SL[g]));
            act = (ph < HA) && (pv < VA);
            if (inb)
                ea = 32'(IB[g] + (pv >> SL[g]) * IW[g] + (ph >> SL[g]));
            else
                ea = 32'(IB[g]);
            ea = ea & 32'h7fff;
            chk("addr", g, addr_w[g], ea);
            chk("frame_start", g, 32'(fs_w[g]), 32'(ph == 0 && pv == 0));

            e.rgb = act ? (inb ? ea[7:0] : BGV[g]) : 8'h00;
            e.hs  = !(ph >= HA + HFP && ph < HA + HFP + HSY);
            e.vs  = !(pv >= VA + VFP && pv < VA + VFP + VSY);
            e.bn  = act;
            sb[g].push_back(e);

            for (int i = 0; i < NV; i++) begin
                if (tbl[i].g == g && tbl[i].h == ph && tbl[i].v == pv) begin
                    chk("tbl_addr", g, addr_w[g], tbl[i].addr);
                    tp_valid[g] = 1'b1;
                    tp_rgb[g]   = tbl[i].rgb;
                    tp_bn[g]    = tbl[i].bn;
                end
            end

            if (ph == HT - 1) begin
                mh[g] = 0;
                mv[g] = (pv == VT - 1) ? 0 : pv + 1;
            end else begin
                mh[g] = ph + 1;
            end
        end else begin
            md[g] = md[g] + 1;
            chk("frame_start_idle", g, 32'(fs_w[g]), 32'd0);
        end

        chk("vga_clk", g, 32'(vclk_w[g]), 32'(md[g] >= cd / 2));
        chk("sync_n", g, 32'(sn_w[g]), 32'd0);

        if (hs_prev[g] && !hs_w[g]) begin
            if (last_hf[g] >= 0)
                chk("hsync_period", g, 32'(cc - last_hf[g]), 32'(HT * cd));
            last_hf[g] = cc;
        end
        if (!hs_prev[g] && hs_w[g])
            chk("hsync_low", g, 32'(cc - last_hf[g]), 32'(HSY * cd));
        if (vs_prev[g] && !vs_w[g])
            last_vf[g] = cc;
        if (!vs_prev[g] && vs_w[g])
            chk("vsync_low", g, 32'(cc - last_vf[g]), 32'(VSY * HT * cd));
        if (fs_w[g]) begin
            if (last_fs[g] >= 0)
                chk("frame_period", g, 32'(cc - last_fs[g]), 32'(HT * VT * cd));
            last_fs[g] = cc;
        end
        hs_prev[g] = hs_w[g];
        vs_prev[g] = vs_w[g];
    endtask

    always begin
        @(posedge clk);
        #1;
        cc++;
        for (int g = 0; g < 2; g++) step(g);
    end

    initial begin
        // dut0: 10x5 image x4 at base 0; dut1: 50x30 image x1 at 1024, clipped
        tbl[0]  = '{0, 0,  0,  32'd0,    8'h00, 1'b1};
        tbl[1]  = '{0, 3,  0,  32'd0,    8'h00, 1'b1};
        tbl[2]  = '{0, 4,  0,  32'd1,    8'h01, 1'b1};
        tbl[3]  = '{0, 0,  4,  32'd10,   8'h0A, 1'b1};
        tbl[4]  = '{0, 39, 19, 32'd49,   8'h31, 1'b1};
        tbl[5]  = '{0, 39, 20, 32'd0,    8'h20, 1'b1};
        tbl[6]  = '{0, 40, 0,  32'd0,    8'h00, 1'b0};
        tbl[7]  = '{1, 0,  0,  32'd1024, 8'h00, 1'b1};
        tbl[8]  = '{1, 39, 0,  32'd1063, 8'h27, 1'b1};
        tbl[9]  = '{1, 39, 23, 32'd2213, 8'hA5, 1'b1};
        tbl[10] = '{1, 45, 0,  32'd1069, 8'h00, 1'b0};
        tbl[11] = '{1, 50, 0,  32'd1024, 8'h00, 1'b0};
        tbl[12] = '{1, 10, 29, 32'd2484, 8'h00, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (14000) @(negedge clk);
        // single-cycle reset in the middle of a frame
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8000) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
